opendap_swd_host: RTL

- SWD host (probe-side) serial engine. It is the initiating end of the link that our SW-DP answers.
- Takes one DP/AP transfer or line-reset command at a time on a valid/ready interface.
- Generates SWCLK from the system clock, serialises the request header and write data, and samples ACK, read data and parity.
- Returns one response per command. It sits between a host command FIFO or CPU bridge and the SWDIO/SWCLK pads.

---
 rtl/opendap_swd_pkg.sv | 34 +++
 rtl/opendap_swd_host_clkgen.sv | 41 ++++
 rtl/opendap_swd_host.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/opendap_swd_pkg.sv
// Shared definitions for the SWD host engine: ACK codes, phase encoding and
// the request-header builder.
package opendap_swd_pkg;

    // ACK as seen on the wire, bit0 = first bit received
    localparam logic [2:0] ACK_OK    = 3'b001;
    localparam logic [2:0] ACK_WAIT  = 3'b010;
    localparam logic [2:0] ACK_FAULT = 3'b100;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_HDR,
        ST_TRN1,
        ST_ACK,
        ST_RDATA,
        ST_TRN2,
        ST_WDATA,
        ST_LRST,
        ST_TAIL
    } swd_state_e;

    function automatic logic hdr_parity(input logic ap_ndp, input logic r_nw,
                                        input logic [1:0] addr);
        return ap_ndp ^ r_nw ^ addr[0] ^ addr[1];
    endfunction

    // Bit 0 is the first bit on the wire: start, APnDP, RnW, A2, A3, parity, stop, park
    function automatic logic [7:0] swd_header(input logic ap_ndp, input logic r_nw,
                                              input logic [1:0] addr);
        return {1'b1, 1'b0, hdr_parity(ap_ndp, r_nw, addr), addr[1], addr[0],
                r_nw, ap_ndp, 1'b1};
    endfunction

endpackage

// File: rtl/opendap_swd_host_clkgen.sv
// SWCLK generator: toggles every CLK_DIV clk cycles while enabled, otherwise
// parks low. Strobes mark the clk edge on which swclk rises or falls.
module opendap_swd_host_clkgen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    output logic swclk_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic          swclk_q;
    logic          tick;

    assign tick     = en_i && (cnt_q == CNT_LAST);
    assign rise_o   = tick && !swclk_q;
    assign fall_o   = tick && swclk_q;
    assign swclk_o  = swclk_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            swclk_q <= 1'b0;
        end else if (!en_i) begin
            cnt_q   <= '0;
            swclk_q <= 1'b0;
        end else if (tick) begin
            cnt_q   <= '0;
            swclk_q <= ~swclk_q;
        end else begin
            cnt_q   <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/opendap_swd_host.sv
// SWD host serial engine: runs one DP/AP transfer or line reset per command
// and returns one response. Bits are driven on SWCLK falls, sampled on rises.
module opendap_swd_host
    import opendap_swd_pkg::*;
#(
    parameter int CLK_DIV        = 2,
    parameter int IDLE_CYCLES    = 2,
    parameter int LINERESET_ONES = 56
) (
    input  logic        clk,
    input  logic        rst,
    output logic        swclk_o,
    output logic        swdo_o,
    output logic        swdo_en_o,
    input  logic        swdi_i,
    input  logic        cmd_valid_i,
    output logic        cmd_rdy_o,
    input  logic        cmd_linereset_i,
    input  logic        cmd_ap_ndp_i,
    input  logic        cmd_r_nw_i,
    input  logic [1:0]  cmd_addr_i,
    input  logic [31:0] cmd_wdata_i,
    output logic        rsp_valid_o,
    output logic [2:0]  rsp_ack_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_parity_err_o
);

    localparam int MAXB0 = (LINERESET_ONES > 33) ? LINERESET_ONES : 33;
    localparam int MAXB  = (IDLE_CYCLES > MAXB0) ? IDLE_CYCLES : MAXB0;
    localparam int BW    = $clog2(MAXB + 1);
    localparam logic [BW-1:0] HDR_LAST  = BW'(7);
    localparam logic [BW-1:0] ACK_LAST  = BW'(2);
    localparam logic [BW-1:0] DATA_LAST = BW'(32);
    localparam logic [BW-1:0] LR_LAST   = BW'(LINERESET_ONES - 1);
    localparam logic [BW-1:0] TAIL_LAST = BW'((IDLE_CYCLES > 0) ? IDLE_CYCLES - 1 : 0);
    localparam bit            HAS_TAIL  = (IDLE_CYCLES > 0);

    swd_state_e    state_q;
    logic [BW-1:0] bit_q;
    logic [6:0]    hdr_q;
    logic [32:0]   data_q;   // {parity, data}: write payload out, read payload in
    logic [2:0]    ack_q;
    logic          rnw_q;
    logic          swdo_q, swdo_en_q, cmd_rdy_q;
    logic          rsp_valid_q, rsp_perr_q;
    logic [2:0]    rsp_ack_q;
    logic [31:0]   rsp_rdata_q;

    logic       rise, fall;
    logic       rd_ok, wr_ok, body_done, finish;
    logic [7:0] hdr_w;

    opendap_swd_host_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
        .clk     (clk),
        .rst     (rst),
        .en_i    (state_q != ST_IDLE),
        .swclk_o (swclk_o),
        .rise_o  (rise),
        .fall_o  (fall)
    );

    assign hdr_w = swd_header(cmd_ap_ndp_i, cmd_r_nw_i, cmd_addr_i);

    always_comb begin
        rd_ok     = (ack_q == ACK_OK) && rnw_q;
        wr_ok     = (ack_q == ACK_OK) && !rnw_q;
        body_done = 1'b0;
        case (state_q)
            ST_TRN2:  body_done = !wr_ok;
            ST_WDATA: body_done = (bit_q == DATA_LAST);
            ST_LRST:  body_done = (bit_q == LR_LAST);
            default:  body_done = 1'b0;
        endcase
        finish = (body_done && !HAS_TAIL) || (state_q == ST_TAIL && bit_q == TAIL_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bit_q       <= '0;
            hdr_q       <= '0;
            data_q      <= '0;
            ack_q       <= '0;
            rnw_q       <= 1'b0;
            swdo_q      <= 1'b0;
            swdo_en_q   <= 1'b0;
            cmd_rdy_q   <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_ack_q   <= '0;
            rsp_rdata_q <= '0;
            rsp_perr_q  <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            if (rsp_valid_q) cmd_rdy_q <= 1'b1;

            if (state_q == ST_IDLE) begin
                if (cmd_valid_i && cmd_rdy_q) begin
                    state_q   <= cmd_linereset_i ? ST_LRST : ST_HDR;
                    cmd_rdy_q <= 1'b0;
                    bit_q     <= '0;
                    hdr_q     <= hdr_w[7:1];
                    data_q    <= {^cmd_wdata_i, cmd_wdata_i};
                    ack_q     <= '0;
                    rnw_q     <= cmd_r_nw_i && !cmd_linereset_i;
                    swdo_q    <= cmd_linereset_i | hdr_w[0];
                    swdo_en_q <= 1'b1;
                end
            end else if (rise) begin
                if (state_q == ST_ACK)   ack_q  <= {swdi_i, ack_q[2:1]};
                if (state_q == ST_RDATA) data_q <= {swdi_i, data_q[32:1]};
            end else if (fall) begin
                if (finish) begin
                    state_q     <= ST_IDLE;
                    swdo_q      <= 1'b0;
                    swdo_en_q   <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    rsp_ack_q   <= ack_q;
                    rsp_rdata_q <= rd_ok ? data_q[31:0] : 32'h0;
                    rsp_perr_q  <= rd_ok && ((^data_q[31:0]) != data_q[32]);
                end else if (body_done) begin
                    state_q   <= ST_TAIL;
                    bit_q     <= '0;
                    swdo_q    <= 1'b0;
                    swdo_en_q <= 1'b1;
                end else begin
                    bit_q <= bit_q + BW'(1);
                    case (state_q)
                        ST_HDR: begin
                            if (bit_q == HDR_LAST) begin
                                state_q   <= ST_TRN1;
                                bit_q     <= '0;
                                swdo_q    <= 1'b0;
                                swdo_en_q <= 1'b0;
                            end else begin
                                swdo_q <= hdr_q[0];
                                hdr_q  <= {1'b0, hdr_q[6:1]};
                            end
                        end
                        ST_TRN1: begin
                            state_q <= ST_ACK;
                            bit_q   <= '0;
                        end
                        ST_ACK: begin
                            if (bit_q == ACK_LAST) begin
                                state_q <= rd_ok ? ST_RDATA : ST_TRN2;
                                bit_q   <= '0;
                            end
                        end
                        ST_RDATA: begin
                            if (bit_q == DATA_LAST) begin
                                state_q <= ST_TRN2;
                                bit_q   <= '0;
                            end
                        end
                        // Only a write with ACK=OK reaches here; the turnaround hands the line back
                        ST_TRN2: begin
                            state_q   <= ST_WDATA;
                            bit_q     <= '0;
                            swdo_q    <= data_q[0];
                            swdo_en_q <= 1'b1;
                        end
                        ST_WDATA: begin
                            swdo_q <= data_q[1];
                            data_q <= {1'b0, data_q[32:1]};
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign swdo_o           = swdo_q;
    assign swdo_en_o        = swdo_en_q;
    assign cmd_rdy_o        = cmd_rdy_q;
    assign rsp_valid_o      = rsp_valid_q;
    assign rsp_ack_o        = rsp_ack_q;
    assign rsp_rdata_o      = rsp_rdata_q;
    assign rsp_parity_err_o = rsp_perr_q;

endmodule
